// File: rtl/frogger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_pkg
//  Description : Shared state encoding, default timing/lives constants and a
//                saturating level helper for the frogger game controller.
//  Revision    : 1.0  initial release
// ============================================================================
package frogger_pkg;

   // Encoded FSM state, also driven out on state_o
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PLAY     = 3'd1,
      ST_DYING    = 3'd2,
      ST_WIN      = 3'd3,
      ST_GAMEOVER = 3'd4
   } state_t;

   localparam int unsigned C_STATE_W          = 3;
   localparam int unsigned C_TIMER_W          = 8;
   localparam int unsigned C_LIVES_INIT_DEF   = 3;
   localparam int unsigned C_DEATH_FRAMES_DEF = 60;
   localparam int unsigned C_GRACE_FRAMES_DEF = 30;
   localparam int unsigned C_WIN_FRAMES_DEF   = 45;
   localparam logic [3:0]  C_LEVEL_MAX        = 4'd15;

   // Next level, holding at the top level instead of wrapping to 0
   function automatic logic [3:0] level_inc(input logic [3:0] lvl);
      return (lvl == C_LEVEL_MAX) ? lvl : lvl + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl_if
//  Description : Frame/button/collision inputs and status outputs of the
//                game controller. slave = controller, master = environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface game_ctrl_if;
   logic       frame_tick;
   logic       start_btn;
   logic       collision_i;
   logic       frog_at_goal;
   logic       pseudo_o;
   logic       freeze_o;
   logic       respawn_o;
   logic [1:0] lives_o;
   logic [3:0] level_o;
   logic       game_over_o;
   logic [2:0] state_o;

   modport slave (
      input  frame_tick, start_btn, collision_i, frog_at_goal,
      output pseudo_o, freeze_o, respawn_o, lives_o, level_o, game_over_o, state_o
   );

   modport master (
      output frame_tick, start_btn, collision_i, frog_at_goal,
      input  pseudo_o, freeze_o, respawn_o, lives_o, level_o, game_over_o, state_o
   );
endinterface
`default_nettype wire

// File: rtl/game_ctrl_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_timer
//  Description : Loadable down-counter stepped by frame ticks. Holds at zero;
//                done_o is high while the count is zero. Load beats tick.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             load_i,
   input  wire logic [WIDTH-1:0] load_val_i,
   input  wire logic             tick_i,
   output logic                  done_o
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   // Next count: reload, or step down on a tick without passing zero
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl
//  Description : Frogger game sequencer: start, grace period, collision and
//                goal handling, death/win pauses, lives and level tracking.
//  Revision    : 1.0  initial release
// ============================================================================
module game_ctrl
   import frogger_pkg::*;
#(
   parameter int unsigned LIVES_INIT   = C_LIVES_INIT_DEF,
   parameter int unsigned DEATH_FRAMES = C_DEATH_FRAMES_DEF,
   parameter int unsigned GRACE_FRAMES = C_GRACE_FRAMES_DEF,
   parameter int unsigned WIN_FRAMES   = C_WIN_FRAMES_DEF
) (
   input  wire logic    clk_in,
   input  wire logic    reset_in,
   game_ctrl_if.slave   bus
);

   localparam logic [1:0]           C_LIVES_LD = LIVES_INIT[1:0];
   localparam logic [C_TIMER_W-1:0] C_DEATH_LD = DEATH_FRAMES[C_TIMER_W-1:0];
   localparam logic [C_TIMER_W-1:0] C_GRACE_LD = GRACE_FRAMES[C_TIMER_W-1:0];
   localparam logic [C_TIMER_W-1:0] C_WIN_LD   = WIN_FRAMES[C_TIMER_W-1:0];

   state_t               state_d, state_q;
   logic [1:0]           lives_d, lives_q;
   logic [3:0]           level_d, level_q;
   logic                 respawn_d, respawn_q;
   logic                 armed_d, armed_q;
   logic                 grace_load;
   logic                 grace_done;
   logic                 pause_load;
   logic [C_TIMER_W-1:0] pause_val;
   logic                 pause_done;
   logic                 pseudo;

   // Collision checking only once the grace period after a PLAY entry is over
   assign pseudo = (state_q == ST_PLAY) && grace_done;

   // The checker answers one cycle after being enabled, so a hit only counts
   // when the enable was already high on the previous cycle
   assign armed_d = pseudo;

   frame_timer #(.WIDTH(C_TIMER_W)) u_grace (
      .clk        (clk_in),
      .rst        (reset_in),
      .load_i     (grace_load),
      .load_val_i (C_GRACE_LD),
      .tick_i     (bus.frame_tick),
      .done_o     (grace_done)
   );

   frame_timer #(.WIDTH(C_TIMER_W)) u_pause (
      .clk        (clk_in),
      .rst        (reset_in),
      .load_i     (pause_load),
      .load_val_i (pause_val),
      .tick_i     (bus.frame_tick),
      .done_o     (pause_done)
   );

   // Next-state, lives/level update and timer loads
   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      level_d    = level_q;
      respawn_d  = 1'b0;
      grace_load = 1'b0;
      pause_load = 1'b0;
      pause_val  = C_DEATH_LD;
      case (state_q)
         ST_IDLE, ST_GAMEOVER: begin
            if (bus.start_btn) begin
               state_d    = ST_PLAY;
               lives_d    = C_LIVES_LD;
               level_d    = 4'd0;
               respawn_d  = 1'b1;
               grace_load = 1'b1;
            end
         end
         ST_PLAY: begin
            // A qualified hit takes priority over reaching the goal
            if (armed_q && bus.collision_i) begin
               state_d    = ST_DYING;
               if (lives_q != 2'd0) begin
                  lives_d = lives_q - 2'd1;
               end
               pause_load = 1'b1;
               pause_val  = C_DEATH_LD;
            end else if (bus.frog_at_goal) begin
               state_d    = ST_WIN;
               level_d    = level_inc(level_q);
               pause_load = 1'b1;
               pause_val  = C_WIN_LD;
            end
         end
         ST_DYING: begin
            if (pause_done) begin
               if (lives_q == 2'd0) begin
                  state_d = ST_GAMEOVER;
               end else begin
                  state_d    = ST_PLAY;
                  respawn_d  = 1'b1;
                  grace_load = 1'b1;
               end
            end
         end
         ST_WIN: begin
            if (pause_done) begin
               state_d    = ST_PLAY;
               respawn_d  = 1'b1;
               grace_load = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and status registers
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q   <= ST_IDLE;
         lives_q   <= 2'd0;
         level_q   <= 4'd0;
         respawn_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         level_q   <= level_d;
         respawn_q <= respawn_d;
         armed_q   <= armed_d;
      end
   end

   assign bus.pseudo_o    = pseudo;
   assign bus.freeze_o    = (state_q != ST_PLAY);
   assign bus.respawn_o   = respawn_q;
   assign bus.lives_o     = lives_q;
   assign bus.level_o     = level_q;
   assign bus.game_over_o = (state_q == ST_GAMEOVER);
   assign bus.state_o     = state_q;

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 Parameter DEATH_FRAMES, default 60, frame ticks spent in DYING.
REQ-003 Parameter GRACE_FRAMES, default 30, frame ticks of invulnerability after each PLAY entry.
REQ-004 Parameter WIN_FRAMES, default 45, frame ticks spent in WIN.
REQ-005 clk_in  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-006 reset_in  input  1  synchronous, active-high reset.
REQ-007 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-008 start_btn  input  1  debounced start request, level.
REQ-009 collision_i  input  1  registered hit flag from the collision checker.
REQ-010 frog_at_goal  input  1  frog occupies the goal row, level.
REQ-011 pseudo_o  output  1  collision-checker enable.
REQ-012 freeze_o  output  1  hold frog and car motion.
REQ-013 respawn_o  output  1  one-cycle pulse: return the frog to its start position.
REQ-014 lives_o  output  2  remaining lives.
REQ-015 level_o  output  4  current level.
REQ-016 game_over_o  output  1  high while in GAMEOVER.
REQ-017 state_o  output  3  encoded FSM state, for display and debug.

Function
REQ-018 FSM states: IDLE, PLAY, DYING, WIN, GAMEOVER.
REQ-019 IDLE or GAMEOVER with start_btn=1: go to PLAY, load lives_o=LIVES_INIT, set level_o=0, pulse respawn_o.
REQ-020 start_btn SHALL be ignored in PLAY, DYING and WIN.
REQ-021 Every PLAY entry loads grace counter=GRACE_FRAMES; each frame_tick decrements it, stopping at 0.
REQ-022 pseudo_o=1 only in PLAY with grace counter=0; all other times pseudo_o=0.
REQ-023 An armed flag SHALL be set when pseudo_o was 1 in the previous cycle, covering the checker's one-cycle latency.
REQ-024 PLAY, armed, collision_i=1: next cycle enter DYING and decrement lives_o by 1.
REQ-025 PLAY, frog_at_goal=1, no qualifying collision: enter WIN and increment level_o, saturating at 15.
REQ-026 Collision and goal qualified in the same cycle: collision wins.
REQ-027 The goal condition is honoured during grace (no collision needed).
REQ-028 DYING and WIN each load a frame timer with DEATH_FRAMES or WIN_FRAMES on entry.
REQ-029 The frame timer decrements on frame_tick; the state exits on the cycle after the tick that takes the timer to 0.
REQ-030 DYING exit: lives_o=0 goes to GAMEOVER with no respawn_o; otherwise go to PLAY and pulse respawn_o.
REQ-031 WIN exit: go to PLAY and pulse respawn_o.
REQ-032 freeze_o=1 in IDLE, DYING, WIN and GAMEOVER; freeze_o=0 in PLAY.
REQ-033 respawn_o SHALL be exactly one clk_in cycle wide per transition.
REQ-034 lives_o never wraps: decrement occurs only from a value of 1 or more.

Reset
REQ-035 reset_in=1 at a rising edge forces IDLE in any state, including mid-DYING or mid-WIN.
REQ-036 Reset values: pseudo_o=0, freeze_o=1, respawn_o=0, lives_o=0, level_o=0, game_over_o=0, state_o=IDLE.
REQ-037 Reset clears the armed flag, grace counter and frame timer.

Structure
REQ-038 Shared package frogger_pkg SHALL hold the state enumeration, state_o encoding and the default timing and lives constants.
REQ-039 Sub-module frame_timer: loadable down-counter decremented by frame_tick, with a done flag; instantiated for the DYING/WIN timer and the grace counter.

Verification
REQ-040 Reset, then start_btn -> respawn_o one pulse; lives_o=3; pseudo_o=0 for 30 ticks, then 1.
REQ-041 collision_i=1 during grace -> no state change, lives_o stays 3.
REQ-042 Armed PLAY, collision_i=1 -> DYING, lives_o=2; after 60 ticks PLAY plus respawn_o; on the third death -> GAMEOVER, game_over_o=1, no respawn_o.
REQ-043 frog_at_goal and collision_i high in the same armed cycle -> DYING, level_o unchanged.
REQ-044 16 goals in succession -> level_o saturates at 15; each WIN lasts 45 ticks.
REQ-045 reset_in at tick 20 of DYING -> next cycle IDLE, all outputs at reset values.
